alu_cluster: RTL and testbench
==============================

# alu_cluster

Parametrised multi-core ALU cluster: NUM_CORES independent WIDTH-bit ALU cores behind a valid/ready dispatch port, with multi-cycle multiply and a round-robin arbitrated, back-pressurable result port. Successor to the fixed 4-core 8-bit multicore ALU. Adds per-core occupancy, operation tagging, an error flag and output flow control. Sits between the instruction issue logic and the result writeback path.

## Interface
- WIDTH, 8, operand width; results are 2*WIDTH bits
- NUM_CORES, 4, number of cores; power of two, >= 2; CW = $clog2(NUM_CORES)
- MUL_CYCLES, 3, multiply execute latency in cycles; >= 1
- TAG_W, 4, width of the caller tag carried with each operation
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high (one clock; synchronous active-high reset)
- in_valid  in  1  operation offered
- in_ready  out  1  combinational: !busy[in_core]
- in_a, in_b  in  WIDTH  unsigned operands
- in_core  in  CW  target core
- in_op  in  2  00 add, 01 sub, 10 mul, 11 reserved
- in_tag  in  TAG_W  caller tag
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts
- out_result  out  2*WIDTH  result
- out_core  out  CW  core that produced it
- out_tag  out  TAG_W  tag of the operation
- out_err  out  1  reserved opcode executed
- busy  out  NUM_CORES  per-core occupancy (registered)

## Operation
- Accept: in_valid && in_ready at a rising edge. The target core latches in_a, in_b, in_op and in_tag, sets busy, and enters EXEC.
- Core FSM: IDLE -> EXEC -> DONE -> IDLE.
  - EXEC loads cnt = L-1. L = MUL_CYCLES for mul, otherwise 1.
  - Each edge in EXEC: if cnt==0, register the result and go to DONE; else cnt--.
  - DONE holds the result until the core is granted.
  - Grant edge: the core returns to IDLE and busy clears.
- Arithmetic (2*WIDTH result):
  - add: zero-extended A+B.
  - sub: (A-B) mod 2^(2*WIDTH).
  - mul: unsigned A*B.
  - 11: result 0, err=1. For all other ops err=0.
- Output register loads when (!out_valid || out_ready) and at least one core is DONE.
  - Grant is round-robin: search starts at (last granted + 1) mod NUM_CORES.
  - After reset the pointer is set so that core 0 has highest priority.
  - Loads out_result, out_core, out_tag, out_err and sets out_valid.
  - If out_valid && out_ready and no core is DONE, out_valid clears.
- Stall: while out_valid && !out_ready, all out_* hold stable, DONE cores stay DONE, and their busy bits stay high.
- in_valid with in_ready low: ignored, no state change.
- Only one accept per cycle. Cores run concurrently and finish out of order; the tag identifies each result.

## Timing
- Reset values: out_valid=0, out_result=0, out_core=0, out_tag=0, out_err=0, busy=0, all cores IDLE, so in_ready=1.
- Uncontended latency: accept at edge k, DONE after edge k+L, out_valid high after edge k+L+1.
  - add/sub/11: 2 cycles.
  - mul with MUL_CYCLES=3: 4 cycles.
- busy[c] is high from accept edge k to the grant edge. The next accept to the same core is possible at the edge after the grant at the earliest: per core, one operation every L+2 cycles.
- Contention: each additional DONE core waits one cycle per grant ahead of it, plus any out_ready stall.
- rst asserted mid-operation: all in-flight and DONE results are discarded. After the reset edge, outputs take their reset values; no partial result is ever emitted.
- rst has priority over a same-edge accept or grant.

## Test plan
- Reset, then add core0 A=200 B=100 tag=5 -> out_valid 2 cycles after accept with out_result=0x012C, out_core=0, out_tag=5, out_err=0.
- Sub core1 A=3 B=5 -> out_result=0xFFFE. Op 11 on core3 A=7 B=9 -> out_result=0, out_err=1.
- Mul core2 A=255 B=255 -> out_result=0xFE01 exactly 4 cycles after accept. in_ready with in_core=2 stays low from the accept edge through the grant edge. A second accept to core2 succeeds at the following edge.
- Collision, with out_ready=1 throughout:
  - Mul to core0 at edge k, add to core1 at edge k+2; both DONE after edge k+3.
  - Core0 result is presented after edge k+4, core1 after edge k+5.
  - Repeat the collision: core1's result precedes core0's (round-robin).
- Back-pressure: hold out_ready=0 for 5 cycles with a result pending.
  - out_* remain stable and busy of the waiting cores stays high.
  - Releasing out_ready drains the results one per cycle in round-robin order.
- Reset mid-operation: assert rst one cycle after a mul accept -> no out_valid afterwards, busy=0, in_ready=1, and a fresh add completes normally.

Source files
------------

// File: rtl/alu_cluster.sv
// rtl/alu_cluster.sv - NUM_CORES independent ALU cores with valid/ready dispatch
// and a round-robin arbitrated, back-pressurable result register.
module alu_cluster #(
  parameter int WIDTH      = 8,
  parameter int NUM_CORES  = 4,
  parameter int MUL_CYCLES = 3,
  parameter int TAG_W      = 4,
  localparam int CW        = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [CW-1:0]        in_core,
  input  logic [1:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic [CW-1:0]        out_core,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err,
  output logic [NUM_CORES-1:0] busy
);

  localparam int RW   = 2 * WIDTH;
  localparam int CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q [NUM_CORES];
  state_t            state_d [NUM_CORES];
  logic [CNTW-1:0]   cnt_q   [NUM_CORES];
  logic [CNTW-1:0]   cnt_d   [NUM_CORES];
  logic [WIDTH-1:0]  a_q     [NUM_CORES];
  logic [WIDTH-1:0]  b_q     [NUM_CORES];
  logic [1:0]        op_q    [NUM_CORES];
  logic [TAG_W-1:0]  tag_q   [NUM_CORES];
  logic [RW-1:0]     res_q   [NUM_CORES];
  logic              err_q   [NUM_CORES];

  logic              accept;
  logic              out_load;
  logic              gnt_any;
  logic [CW-1:0]     gnt_idx;
  logic [CW-1:0]     last_q;

  function automatic logic [RW-1:0] alu(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [1:0] op);
    logic [RW-1:0] ae;
    logic [RW-1:0] be;
    ae = RW'(a);
    be = RW'(b);
    case (op)
      2'b00:   return ae + be;
      2'b01:   return ae - be;
      2'b10:   return ae * be;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      busy[c] = (state_q[c] != IDLE);
    end
  end

  assign in_ready = !busy[in_core];
  assign accept   = in_valid && in_ready;

  // Round-robin: scan from last_q+1, wrapping; last_q itself is checked last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_q;
    for (int i = 1; i <= NUM_CORES; i++) begin
      if (!gnt_any && state_q[last_q + CW'(i)] == DONE) begin
        gnt_any = 1'b1;
        gnt_idx = last_q + CW'(i);
      end
    end
  end

  assign out_load = (!out_valid || out_ready) && gnt_any;

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        IDLE: if (accept && in_core == CW'(c)) begin
          state_d[c] = EXEC;
          cnt_d[c]   = (in_op == 2'b10) ? CNTW'(MUL_CYCLES - 1) : '0;
        end
        EXEC: if (cnt_q[c] == '0) state_d[c] = DONE;
              else cnt_d[c] = cnt_q[c] - CNTW'(1);
        DONE: if (out_load && gnt_idx == CW'(c)) state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        a_q[c]     <= '0;
        b_q[c]     <= '0;
        op_q[c]    <= '0;
        tag_q[c]   <= '0;
        res_q[c]   <= '0;
        err_q[c]   <= 1'b0;
      end
      out_valid  <= 1'b0;
      out_result <= '0;
      out_core   <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      last_q     <= CW'(NUM_CORES - 1);
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        if (state_q[c] == IDLE && accept && in_core == CW'(c)) begin
          a_q[c]   <= in_a;
          b_q[c]   <= in_b;
          op_q[c]  <= in_op;
          tag_q[c] <= in_tag;
        end
        if (state_q[c] == EXEC && cnt_q[c] == '0) begin
          res_q[c] <= alu(a_q[c], b_q[c], op_q[c]);
          err_q[c] <= (op_q[c] == 2'b11);
        end
      end
      if (out_load) begin
        out_valid  <= 1'b1;
        out_result <= res_q[gnt_idx];
        out_core   <= gnt_idx;
        out_tag    <= tag_q[gnt_idx];
        out_err    <= err_q[gnt_idx];
        last_q     <= gnt_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cluster.sv
// tb/tb_alu_cluster.sv - scoreboard bench for alu_cluster with directed vectors.
module tb_alu_cluster;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_core;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [1:0]  out_core;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [3:0]  busy;

  alu_cluster dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_core(in_core), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_core(out_core), .out_tag(out_tag), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [1:0]  core;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t head;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the presented result to the queue head; pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got result 0x%0h core %0d tag %0d with nothing expected",
                 out_result, out_core, out_tag);
      end else begin
        head = q[0];
        chk("out_fields", 32'({out_result, out_core, out_tag, out_err}),
            32'({head.res, head.core, head.tag, head.err}));
        if (out_ready) begin
          if (head.cyc >= 0) chk("out_cycle", 32'(cyc), 32'(head.cyc));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] core, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag, output int k);
    in_valid = 1'b1;
    in_core  = core;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    #1;
    chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    k = cyc;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] res, input logic [1:0] core, input logic [3:0] tag,
                      input logic err, input int c);
    exp_t e;
    e.res  = res;
    e.core = core;
    e.tag  = tag;
    e.err  = err;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      tick(1);
      t++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    int k, k2, k3;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_core = '0;
    in_op = '0; in_tag = '0; out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_core",   32'(out_core),   32'd0);
    chk("rst_out_tag",    32'(out_tag),    32'd0);
    chk("rst_out_err",    32'(out_err),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);

    // Single-core add, sub and reserved opcode.
    issue(2'd0, 2'b00, 8'd200, 8'd100, 4'd5, k); push(16'h012C, 2'd0, 4'd5, 1'b0, k + 2); drain();
    issue(2'd1, 2'b01, 8'd3, 8'd5, 4'd6, k);     push(16'hFFFE, 2'd1, 4'd6, 1'b0, k + 2); drain();
    issue(2'd3, 2'b11, 8'd7, 8'd9, 4'd7, k);     push(16'h0000, 2'd3, 4'd7, 1'b1, k + 2); drain();

    // Mul on core2, with a second op held on core2 until it frees up.
    issue(2'd2, 2'b10, 8'd255, 8'd255, 4'd8, k); push(16'hFE01, 2'd2, 4'd8, 1'b0, k + 4);
    in_valid = 1'b1; in_core = 2'd2; in_op = 2'b00; in_a = 8'd1; in_b = 8'd2; in_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("in_ready_core2_busy", 32'(in_ready), 32'd0);
      chk("busy2_high", 32'(busy[2]), 32'd1);
      @(posedge clk);
      #1;
    end
    #1;
    chk("in_ready_core2_free", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    k2 = cyc;
    in_valid = 1'b0;
    push(16'h0003, 2'd2, 4'd9, 1'b0, k2 + 2);
    drain();

    // Collision: last grant was core2, so core0 wins first.
    issue(2'd0, 2'b10, 8'd12, 8'd13, 4'd1, k); tick(1);
    issue(2'd1, 2'b00, 8'd255, 8'd1, 4'd2, k2);
    push(16'h009C, 2'd0, 4'd1, 1'b0, k + 4);
    push(16'h0100, 2'd1, 4'd2, 1'b0, k + 5);
    drain();

    // Make core0 the last grant, then collide again: core1 wins first.
    issue(2'd0, 2'b00, 8'd1, 8'd1, 4'd3, k); push(16'h0002, 2'd0, 4'd3, 1'b0, k + 2); drain();
    issue(2'd0, 2'b10, 8'd2, 8'd3, 4'd4, k); tick(1);
    issue(2'd1, 2'b01, 8'd10, 8'd3, 4'd5, k2);
    push(16'h0007, 2'd1, 4'd5, 1'b0, k + 4);
    push(16'h0006, 2'd0, 4'd4, 1'b0, k + 5);
    drain();

    // Back-pressure: three results pending behind a stalled output.
    out_ready = 1'b0;
    issue(2'd1, 2'b00, 8'd5, 8'd6, 4'd10, k);
    issue(2'd3, 2'b01, 8'd9, 8'd4, 4'd11, k2);
    issue(2'd0, 2'b10, 8'd3, 8'd4, 4'd12, k3);
    push(16'h000B, 2'd1, 4'd10, 1'b0, k + 7);
    push(16'h0005, 2'd3, 4'd11, 1'b0, k + 8);
    push(16'h000C, 2'd0, 4'd12, 1'b0, k + 9);
    tick(5);
    chk("stall_busy", 32'(busy), 32'b1001);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();

    // Reset one cycle after a mul accept discards it.
    issue(2'd0, 2'b10, 8'd9, 8'd9, 4'd14, k);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    in_core = 2'd0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    issue(2'd2, 2'b00, 8'd50, 8'd60, 4'd13, k); push(16'h006E, 2'd2, 4'd13, 1'b0, k + 2); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
